// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: stalls fetch on a miss, bursts one line from memory into the cache.
// Optional build macro ICACHE_CWF_EN selects critical-word-first fill order.
module icache_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Imiss,
  input  logic [ADDR_W-1:0] MissAddr,
  input  logic              FlushPipeandPC,
  output logic              PCStall,
  output logic              IF_ID_Flush,
  output logic              RefillBusy,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic              MemRValid,
  input  logic [31:0]       MemRData,
  output logic              CacheWe,
  output logic [ADDR_W-1:0] CacheWAddr,
  output logic [31:0]       CacheWData,
  output logic              CacheValidSet
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] line_base;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  start_idx;
  logic              drop;

  logic              miss_start;
  logic              beat;
  logic              last_beat;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  miss_idx;
  logic [ADDR_W-1:0] miss_base;

  // Line base has its offset bits cleared, so OR-ing the word offset in is an add.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    word_addr = base | {{(ADDR_W-OFF_W){1'b0}}, idx, 2'b00};
  endfunction

  assign miss_start = (state == IDLE) && Imiss && !FlushPipeandPC;
  assign beat       = (state == FILL) && MemRValid;
  assign last_beat  = beat && (cnt == IDX_W'(LINE_WORDS - 1));
  assign widx       = start_idx + cnt;
  assign miss_base  = MissAddr & BASE_MASK;

`ifdef ICACHE_CWF_EN
  assign miss_idx = MissAddr[OFF_W-1:2];
`else
  assign miss_idx = '0;
`endif

  // Stall is combinational so the miss cycle itself holds the PC; gated so reset forces it low.
  assign PCStall     = Rst && ((state != IDLE) || miss_start);
  assign IF_ID_Flush = PCStall;
  assign CacheWe     = beat;
  assign CacheWAddr  = word_addr(line_base, widx);
  assign CacheWData  = beat ? MemRData : 32'd0;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state         <= IDLE;
      line_base     <= '0;
      start_idx     <= '0;
      cnt           <= '0;
      drop          <= 1'b0;
      MemReq        <= 1'b0;
      MemAddr       <= '0;
      RefillBusy    <= 1'b0;
      CacheValidSet <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CacheValidSet <= 1'b0;
          if (miss_start) begin
            state      <= REQ;
            line_base  <= miss_base;
            start_idx  <= miss_idx;
            cnt        <= '0;
            MemAddr    <= word_addr(miss_base, miss_idx);
            MemReq     <= 1'b1;
            RefillBusy <= 1'b1;
          end
        end
        REQ: begin
          if (FlushPipeandPC) drop <= 1'b1;
          if (MemAck) begin
            state  <= FILL;
            cnt    <= '0;
            MemReq <= 1'b0;
          end
        end
        FILL: begin
          if (FlushPipeandPC) drop <= 1'b1;
          if (beat) cnt <= cnt + 1'b1;
          // A redirect on the final beat still counts as stale.
          if (last_beat) begin
            state         <= DONE;
            CacheValidSet <= !(drop || FlushPipeandPC);
          end
        end
        DONE: begin
          state         <= IDLE;
          drop          <= 1'b0;
          CacheValidSet <= 1'b0;
          RefillBusy    <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          MemReq     <= 1'b0;
          RefillBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: driver pushes expected cache writes, monitor checks them.
module tb_icache_refill_ctrl;

  localparam int LW = 4;

  logic        Clk, Rst, Imiss, FlushPipeandPC, MemAck, MemRValid;
  logic [31:0] MissAddr, MemRData;
  logic        PCStall, IF_ID_Flush, RefillBusy, MemReq, CacheWe, CacheValidSet;
  logic [31:0] MemAddr, CacheWAddr, CacheWData;

  icache_refill_ctrl #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Imiss(Imiss), .MissAddr(MissAddr),
    .FlushPipeandPC(FlushPipeandPC), .PCStall(PCStall), .IF_ID_Flush(IF_ID_Flush),
    .RefillBusy(RefillBusy), .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
    .MemRValid(MemRValid), .MemRData(MemRData), .CacheWe(CacheWe),
    .CacheWAddr(CacheWAddr), .CacheWData(CacheWData), .CacheValidSet(CacheValidSet)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_vs[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every cache write and valid-set pulse must match the next expected entry.
  always @(negedge Clk) begin
    if (Rst) begin
      if (CacheWe) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", CacheWAddr, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", CacheWAddr, w.a);
          chk("wr_data", CacheWData, w.d);
        end
      end
      if (CacheValidSet) begin
        if (exp_vs.size() == 0) chk("unexpected_validset", 32'(cyc), 32'hFFFF_FFFF);
        else chk("validset_cycle", 32'(cyc), 32'(exp_vs.pop_front()));
      end
    end
  end

  task automatic idle_inputs();
    Imiss = 0; FlushPipeandPC = 0; MemAck = 0; MemRValid = 0;
    MissAddr = 0; MemRData = 0;
  endtask

  // One full refill transaction; the expected fill order comes from the line/word arithmetic.
  task automatic do_miss(input logic [31:0] addr, input int ack_dly, input int gap_pct,
                         input int flush_pct);
    logic [31:0] base, maddr;
    int start, beats, gaps;
    bit drop;
    base = addr & ~32'(LW * 4 - 1);
`ifdef ICACHE_CWF_EN
    start = int'((addr >> 2) % LW);
`else
    start = 0;
`endif
    maddr = base + 32'(4 * start);
    drop = 0;
    @(posedge Clk); #1;
    idle_inputs();
    Imiss = 1; MissAddr = addr;
    @(negedge Clk);
    chk("miss_stall", PCStall, 1);
    chk("miss_ifid", IF_ID_Flush, 1);
    chk("miss_req", MemReq, 0);
    for (int k = 0; k <= ack_dly; k++) begin
      @(posedge Clk); #1;
      Imiss = 1'($urandom % 2); MissAddr = $urandom;
      MemAck = (k == ack_dly); MemRValid = 1'($urandom % 2); MemRData = $urandom;
      FlushPipeandPC = ($urandom_range(99) < flush_pct);
      if (FlushPipeandPC) drop = 1;
      @(negedge Clk);
      chk("req_memreq", MemReq, 1);
      chk("req_memaddr", MemAddr, maddr);
      chk("req_stall", PCStall, 1);
    end
    beats = 0; gaps = 0;
    while (beats < LW) begin
      @(posedge Clk); #1;
      Imiss = 1'($urandom % 2); MissAddr = $urandom; MemAck = 1'($urandom % 2);
      FlushPipeandPC = ($urandom_range(99) < flush_pct);
      if (FlushPipeandPC) drop = 1;
      MemRValid = ($urandom_range(99) >= gap_pct) || (gaps >= 4);
      MemRData = $urandom;
      if (MemRValid) begin
        exp_wr.push_back('{a: base + 32'(4 * ((start + beats) % LW)), d: MemRData});
        beats++; gaps = 0;
      end else begin
        gaps++;
      end
      @(negedge Clk);
      chk("fill_stall", PCStall, 1);
      chk("fill_memreq", MemReq, 0);
    end
    @(posedge Clk); #1;
    idle_inputs();
    if (!drop) exp_vs.push_back(cyc);
    @(negedge Clk);
    chk("done_stall", PCStall, 1);
    chk("done_busy", RefillBusy, 1);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("release_stall", PCStall, 0);
    chk("release_busy", RefillBusy, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 0; Imiss = 1; FlushPipeandPC = 0; MemAck = 1; MemRValid = 1;
    MissAddr = 32'hDEAD_BEEF; MemRData = 32'hCAFE_F00D;
    #3;
    chk("rst_stall", PCStall, 0);
    chk("rst_ifid", IF_ID_Flush, 0);
    chk("rst_busy", RefillBusy, 0);
    chk("rst_memreq", MemReq, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_we", CacheWe, 0);
    chk("rst_waddr", CacheWAddr, 0);
    chk("rst_wdata", CacheWData, 0);
    chk("rst_validset", CacheValidSet, 0);
    repeat (2) @(posedge Clk);
    #1;
    idle_inputs();
    Rst = 1;
    @(negedge Clk);
    chk("post_rst_stall", PCStall, 0);
    chk("post_rst_busy", RefillBusy, 0);

    do_miss(32'h0000_1048, 0, 0, 0);
    do_miss(32'h0000_2014, 3, 50, 0);
    do_miss(32'h0000_30A8, 1, 20, 100);

    // Redirect coincident with a miss in IDLE: miss is dropped.
    @(posedge Clk); #1;
    Imiss = 1; FlushPipeandPC = 1; MissAddr = 32'h0000_4000;
    @(negedge Clk);
    chk("flushmiss_stall", PCStall, 0);
    @(posedge Clk); #1;
    idle_inputs();
    @(negedge Clk);
    chk("flushmiss_req", MemReq, 0);
    chk("flushmiss_busy", RefillBusy, 0);

    // Reset in the middle of a fill: two beats land, the rest are ignored.
    @(posedge Clk); #1;
    Imiss = 1; MissAddr = 32'h0000_5000;
    @(posedge Clk); #1;
    idle_inputs(); MemAck = 1;
    for (int b = 0; b < 2; b++) begin
      @(posedge Clk); #1;
      idle_inputs(); MemRValid = 1; MemRData = $urandom;
      exp_wr.push_back('{a: 32'h0000_5000 + 32'(4 * b), d: MemRData});
    end
    @(posedge Clk); #1;
    Rst = 0; MemRValid = 1; Imiss = 1; MemRData = $urandom;
    #1;
    chk("midrst_stall", PCStall, 0);
    chk("midrst_busy", RefillBusy, 0);
    chk("midrst_memreq", MemReq, 0);
    chk("midrst_memaddr", MemAddr, 0);
    chk("midrst_we", CacheWe, 0);
    chk("midrst_waddr", CacheWAddr, 0);
    @(negedge Clk);
    Rst = 1; Imiss = 0;
    repeat (3) begin
      @(posedge Clk); #1;
      MemRValid = 1; MemRData = $urandom;
    end
    @(posedge Clk); #1;
    idle_inputs();
    @(negedge Clk);
    chk("late_rvalid_busy", RefillBusy, 0);

    do_miss(32'h0000_6FFC, 0, 0, 0);
    for (int t = 0; t < 40; t++)
      do_miss($urandom, $urandom_range(4), $urandom_range(60), ($urandom % 4 == 0) ? 15 : 0);

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("leftover_writes", 32'(exp_wr.size()), 0);
    chk("leftover_validset", 32'(exp_vs.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
